mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage data access.
- The memory has variable latency and a req/ack handshake.
- Arbitration gives data priority and includes an anti-starvation counter.
- Responses are registered. The pipeline stalls IF/MEM on each requester's ready until its access completes.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_t;

  localparam int DEF_ADDR_W        = 32;
  localparam int DEF_DATA_W        = 32;
  localparam int DEF_MAX_DM_STREAK = 4;

  // Wide enough for the largest allowed streak limit (15).
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: masks requesters that are still holding req
// during their own ready pulse, applies data-first priority with a
// fetch anti-starvation limit, and produces the next streak count.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input  logic                idle,
  input  logic                if_req,
  input  logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_ready,
  input  logic [STREAK_W-1:0] streak,
  output grant_t              grant,
  output logic [STREAK_W-1:0] streak_next
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  logic if_elig;
  logic dm_elig;

  assign if_elig = if_req & ~if_ready;
  assign dm_elig = dm_req & ~dm_ready;

  // Grant decision; the streak only moves when a grant is actually issued.
  always_comb begin
    grant       = GNT_NONE;
    streak_next = streak;
    if (idle) begin
      if (if_elig && dm_elig) begin
        if (streak >= STREAK_MAX) begin
          grant       = GNT_IF;
          streak_next = '0;
        end else begin
          grant       = GNT_DM;
          streak_next = streak + STREAK_W'(1);
        end
      end else if (if_elig) begin
        grant       = GNT_IF;
        streak_next = '0;
      end else if (dm_elig) begin
        grant       = GNT_DM;
        streak_next = '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and data access. One access outstanding at a time; all outputs registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  arb_state_t          state;
  grant_t              grant;
  logic                idle;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_next;

  assign idle = (state == IDLE);

  mem_arb_pick #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_pick (
    .idle       (idle),
    .if_req     (if_req_i),
    .if_ready   (if_ready_o),
    .dm_req     (dm_req_i),
    .dm_ready   (dm_ready_o),
    .streak     (streak),
    .grant      (grant),
    .streak_next(streak_next)
  );

  // FSM plus memory-side and requester-side registers; acks outside BUSY are ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      streak      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ready_o  <= 1'b0;
      dm_ready_o  <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          streak <= streak_next;
          if (grant == GNT_IF) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            state       <= BUSY_IF;
          end else if (grant == GNT_DM) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            state       <= BUSY_DM;
          end
        end
        BUSY_IF: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            if_ready_o <= 1'b1;
            if_rdata_o <= mem_rdata_i;
            state      <= IDLE;
          end
        end
        BUSY_DM: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            dm_ready_o <= 1'b1;
            if (!mem_we_o) begin
              dm_rdata_o <= mem_rdata_i;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ready_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_ready_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] mem_model [0:63];
  bit          auto_mode     = 0;
  int          next_wait     = 0;
  bit          ack_idle_once = 0;
  bit          if_pending = 0, if_hold = 0;
  logic [31:0] if_a = '0;
  bit          dm_pending = 0, dm_hold = 0, dm_w = 0;
  logic [31:0] dm_a = '0, dm_d = '0;
  int          owner = 0;       // 0 = memory free, 1 = fetch, 2 = data
  int          wait_left = 0;
  bit          e_if_ready = 0, e_dm_ready = 0, e_we = 0;
  logic [31:0] e_if_rdata = '0, e_dm_rdata = '0, e_addr = '0, e_wdata = '0;
  int          e_streak = 0;

  task automatic model_reset();
    owner = 0; wait_left = 0;
    e_if_ready = 0; e_dm_ready = 0; e_we = 0;
    e_if_rdata = '0; e_dm_rdata = '0; e_addr = '0; e_wdata = '0; e_streak = 0;
    if_pending = 0; if_hold = 0; dm_pending = 0; dm_hold = 0;
  endtask

  // One clock cycle: drive requesters and memory, advance the model, wait for
  // the edge, then compare every visible output against the model.
  task automatic step();
    bit          ack;
    bit          if_el, dm_el, n_if_ready, n_dm_ready;
    logic [31:0] rd;
    if (auto_mode) begin
      if (!if_pending && $urandom_range(0, 2) == 0) begin
        if_pending = 1; if_a = 32'($urandom_range(0, 63)) << 2;
      end
      if (!dm_pending && $urandom_range(0, 1) == 0) begin
        dm_pending = 1; dm_w = 1'($urandom_range(0, 1));
        dm_a = 32'($urandom_range(0, 63)) << 2; dm_d = $urandom;
      end
    end
    if_req_i = if_pending | if_hold; if_addr_i = if_a;
    dm_req_i = dm_pending | dm_hold; dm_we_i = dm_w;
    dm_addr_i = dm_a; dm_wdata_i = dm_d;

    ack = 0; rd = $urandom;
    if (owner != 0 && wait_left == 0) begin
      ack = 1;
      if (owner == 1 || !e_we) rd = mem_model[e_addr[7:2]];
    end else if (owner == 0 && (ack_idle_once || (auto_mode && $urandom_range(0, 7) == 0))) begin
      ack = 1; ack_idle_once = 0;
    end
    mem_ack_i = ack; mem_rdata_i = rd;

    if_el = if_req_i && !e_if_ready;
    dm_el = dm_req_i && !e_dm_ready;
    n_if_ready = 0; n_dm_ready = 0; if_hold = 0; dm_hold = 0;
    if (owner == 0) begin
      if (dm_el && (!if_el || e_streak < MAXS)) begin
        owner = 2; e_we = dm_w; e_addr = dm_a; e_wdata = dm_d;
        e_streak = if_el ? e_streak + 1 : 0;
      end else if (if_el) begin
        owner = 1; e_we = 0; e_addr = if_a; e_wdata = '0; e_streak = 0;
      end
      if (owner != 0) wait_left = (next_wait >= 0) ? next_wait : int'($urandom_range(0, 3));
    end else if (ack) begin
      if (owner == 1) begin
        n_if_ready = 1; e_if_rdata = rd; if_pending = 0; if_hold = 1;
      end else begin
        n_dm_ready = 1;
        if (e_we) mem_model[e_addr[7:2]] = e_wdata;
        else e_dm_rdata = rd;
        dm_pending = 0; dm_hold = 1;
      end
      owner = 0;
    end else begin
      wait_left--;
    end

    @(posedge clk); #1;
    e_if_ready = n_if_ready; e_dm_ready = n_dm_ready;
    chk("if_ready", if_ready_o, e_if_ready);
    chk("dm_ready", dm_ready_o, e_dm_ready);
    chk("mem_req", mem_req_o, 32'(owner != 0));
    chk("if_rdata", if_rdata_o, e_if_rdata);
    chk("dm_rdata", dm_rdata_o, e_dm_rdata);
    if (owner != 0) begin
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_we", mem_we_o, e_we);
      chk("mem_wdata", mem_wdata_o, e_wdata);
      chk("streak", dut.streak, e_streak);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_if_ready"}, if_ready_o, 0);
    chk({tag, "_dm_ready"}, dm_ready_o, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_dm_rdata"}, dm_rdata_o, 0);
    chk({tag, "_state"}, dut.state, 0);
    chk({tag, "_streak"}, dut.streak, 0);
  endtask

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          preload;
    logic [31:0] mdata;
    int          wt;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    bit done;
    int dm_at, if_at;

    for (int i = 0; i < 64; i++) mem_model[i] = '0;
    rst_n = 0;
    if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
    dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 0;

    //            dm we addr          wdata         pre mdata         wt exp_rdata     lat
    vecs[0] = '{0, 0, 32'h0000_0004, 32'h0,        1, 32'h8C01_0000, 0, 32'h8C01_0000, 2};
    vecs[1] = '{1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,        3, 32'h0000_0000, 5};
    vecs[2] = '{1, 0, 32'h0000_0030, 32'h0,        1, 32'h1234_5678, 1, 32'h1234_5678, 3};
    vecs[3] = '{1, 1, 32'h0000_0034, 32'hCAFE_F00D, 0, 32'h0,        0, 32'h1234_5678, 2};
    vecs[4] = '{0, 0, 32'h0000_0010, 32'h0,        0, 32'h0,        2, 32'hDEAD_BEEF, 4};
    vecs[5] = '{1, 0, 32'h0000_0034, 32'h0,        0, 32'h0,        0, 32'hCAFE_F00D, 2};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1;

    // Directed single transactions; the requester keeps req high through its ready pulse.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].preload) mem_model[vecs[i].addr[7:2]] = vecs[i].mdata;
      next_wait = vecs[i].wt;
      if (vecs[i].dm) begin
        dm_pending = 1; dm_w = vecs[i].we; dm_a = vecs[i].addr; dm_d = vecs[i].wdata;
      end else begin
        if_pending = 1; if_a = vecs[i].addr;
      end
      n = 0; done = 0;
      while (!done && n < 20) begin
        step();
        n++;
        done = vecs[i].dm ? dm_ready_o : if_ready_o;
      end
      chk($sformatf("vec%0d_latency", i), n, vecs[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i), vecs[i].dm ? dm_rdata_o : if_rdata_o, vecs[i].exp_rdata);
      step(); step();
      $display("vec %0d: %s %s addr=0x%08h latency=%0d", i, vecs[i].dm ? "DM" : "IF",
               vecs[i].we ? "write" : "read", vecs[i].addr, n);
    end

    // Simultaneous requests: data first, fetch granted during the data ready pulse.
    next_wait = 0;
    if_pending = 1; if_a = 32'h0;
    dm_pending = 1; dm_w = 0; dm_a = 32'h20;
    n = 0; dm_at = -1; if_at = -1;
    while ((dm_at < 0 || if_at < 0) && n < 30) begin
      step();
      n++;
      if (dm_ready_o && dm_at < 0) dm_at = n;
      if (if_ready_o && if_at < 0) if_at = n;
    end
    chk("simul_dm_done_cycle", dm_at, 2);
    chk("simul_if_done_cycle", if_at, 4);
    step(); step();
    $display("simultaneous: dm ready at %0d, if ready at %0d", dm_at, if_at);

    // Fetch held while data re-requests continuously.
    next_wait = 0;
    if_pending = 1; if_a = 32'h100 & 32'hFC;
    for (int k = 0; k < 16; k++) begin
      if (!dm_pending) begin
        dm_pending = 1; dm_w = 0; dm_a = 32'($urandom_range(0, 63)) << 2;
      end
      step();
    end
    dm_pending = 0; if_pending = 0;
    repeat (12) step();
    $display("starvation sequence: done, streak=%0d", dut.streak);

    // Reset in the middle of a data read, followed by a stale ack.
    next_wait = 6;
    dm_pending = 1; dm_w = 0; dm_a = 32'h40;
    repeat (3) step();
    chk("midrst_busy", mem_req_o, 1);
    #2 rst_n = 0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    if_req_i = 0; dm_req_i = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step();
    ack_idle_once = 1;
    step();
    step();
    chk("stale_ack_no_ready", {30'd0, if_ready_o, dm_ready_o}, 0);
    $display("mid-op reset: stale ack handled");

    // Randomized traffic with random wait states and spurious idle acks.
    auto_mode = 1; next_wait = -1;
    repeat (400) step();
    auto_mode = 0;
    repeat (15) step();
    $display("random traffic: 400 cycles");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
